// File: rtl/hyperram_pkg.sv
// Shared types and helpers for the HyperBus DDR sequencer: FSM states and
// the 48-bit command/address word layout.
package hyperram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_CA       = 3'd2,
    ST_LATENCY  = 3'd3,
    ST_WRITE    = 3'd4,
    ST_READ     = 3'd5,
    ST_CS_HOLD  = 3'd6,
    ST_RECOVER  = 3'd7
  } state_t;

  localparam int CA_WORDS   = 3;
  localparam int DATA_WORDS = 2;

  localparam int CA_RW_BIT    = 47;
  localparam int CA_AS_BIT    = 46;
  localparam int CA_BURST_BIT = 45;
  localparam int CA_ROW_HI    = 44;
  localparam int CA_ROW_LO    = 16;
  localparam int CA_COL_HI    = 2;

  // Memory space, linear burst; upper address bits go to the row field,
  // the low three bits select the half-page column.
  function automatic logic [47:0] build_ca(input logic we, input logic [21:0] addr);
    logic [47:0] ca;
    ca                         = '0;
    ca[CA_RW_BIT]              = ~we;
    ca[CA_AS_BIT]              = 1'b0;
    ca[CA_BURST_BIT]           = 1'b1;
    ca[CA_ROW_HI:CA_ROW_LO]    = 29'(addr[21:3]);
    ca[CA_COL_HI:0]            = addr[2:0];
    return ca;
  endfunction

endpackage

// File: rtl/hyperram_ddr_seq.sv
// Single-transaction HyperBus sequencer producing registered D0/D1 pairs for
// the output DDR cells and collecting read words from the input DDR cells.
module hyperram_ddr_seq
  import hyperram_pkg::*;
#(
  parameter int LAT_CYC     = 12,
  parameter int RECOVER_CYC = 4,
  parameter int TIMEOUT     = 32
) (
  input  logic        SCLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [21:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        cs_n,
  output logic        ck_d0,
  output logic        ck_d1,
  output logic [7:0]  dq_d0,
  output logic [7:0]  dq_d1,
  output logic        dq_oe,
  output logic        rwds_d0,
  output logic        rwds_d1,
  output logic        rwds_oe,
  input  logic [7:0]  dq_q0,
  input  logic [7:0]  dq_q1,
  input  logic        rwds_q0,
  input  logic        rwds_q1
);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [47:0] ca_q, ca_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] rd_hi_q, rd_hi_d;
  logic        got_first_q, got_first_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        cs_n_q, cs_n_d;
  logic        ck_d0_q, ck_d0_d;
  logic        ck_d1_q, ck_d1_d;
  logic [7:0]  dq_d0_q, dq_d0_d;
  logic [7:0]  dq_d1_q, dq_d1_d;
  logic        dq_oe_q, dq_oe_d;
  logic        rwds_oe_q, rwds_oe_d;

  logic        word_valid;

  assign req_ready  = (state_q == ST_IDLE) && !RST;
  assign word_valid = rwds_q0 ^ rwds_q1;

  // Next state and counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    ca_d        = ca_q;
    wdata_d     = wdata_q;
    rd_hi_d     = rd_hi_q;
    got_first_d = got_first_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          ca_d    = build_ca(req_we, req_addr);
          wdata_d = req_wdata;
          state_d = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        state_d = ST_CA;
        cnt_d   = 8'(CA_WORDS - 1);
      end
      ST_CA: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_LATENCY;
          cnt_d   = 8'(LAT_CYC - 1);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_LATENCY: begin
        if (cnt_q == 8'd0) begin
          got_first_d = 1'b0;
          if (we_q) begin
            state_d = ST_WRITE;
            cnt_d   = 8'(DATA_WORDS - 1);
          end else begin
            state_d = ST_READ;
            cnt_d   = 8'(TIMEOUT - 1);
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_WRITE: begin
        if (cnt_q == 8'd0) begin
          state_d     = ST_CS_HOLD;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_READ: begin
        cnt_d = cnt_q - 8'd1;
        if (word_valid && got_first_q) begin
          state_d     = ST_CS_HOLD;
          rsp_rdata_d = {rd_hi_q, dq_q0, dq_q1};
          rsp_err_d   = 1'b0;
        end else begin
          if (word_valid) begin
            rd_hi_d     = {dq_q0, dq_q1};
            got_first_d = 1'b1;
          end
          // A word arriving on the last cycle still leaves the second missing.
          if (cnt_q == 8'd0) begin
            state_d     = ST_CS_HOLD;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end
        end
      end
      ST_CS_HOLD: begin
        state_d = ST_RECOVER;
        cnt_d   = 8'(RECOVER_CYC - 1);
      end
      ST_RECOVER: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so they reach the DDR cells
  // one clock ahead of the pad.
  always_comb begin
    rsp_valid_d = (state_d == ST_CS_HOLD);
    cs_n_d      = (state_d == ST_IDLE) || (state_d == ST_RECOVER);
    ck_d0_d     = 1'b0;
    ck_d1_d     = (state_d == ST_CA) || (state_d == ST_LATENCY) ||
                  (state_d == ST_WRITE) || (state_d == ST_READ);
    dq_oe_d     = (state_d == ST_CA) || (state_d == ST_WRITE);
    rwds_oe_d   = (state_d == ST_WRITE);
    dq_d0_d     = 8'h00;
    dq_d1_d     = 8'h00;

    if (state_d == ST_CA) begin
      unique case (cnt_d[1:0])
        2'd2:    begin dq_d0_d = ca_d[47:40]; dq_d1_d = ca_d[39:32]; end
        2'd1:    begin dq_d0_d = ca_d[31:24]; dq_d1_d = ca_d[23:16]; end
        default: begin dq_d0_d = ca_d[15:8];  dq_d1_d = ca_d[7:0];   end
      endcase
    end else if (state_d == ST_WRITE) begin
      if (cnt_d[0]) begin
        dq_d0_d = wdata_d[31:24];
        dq_d1_d = wdata_d[23:16];
      end else begin
        dq_d0_d = wdata_d[15:8];
        dq_d1_d = wdata_d[7:0];
      end
    end
  end

  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      ca_q        <= '0;
      wdata_q     <= '0;
      rd_hi_q     <= '0;
      got_first_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cs_n_q      <= 1'b1;
      ck_d0_q     <= 1'b0;
      ck_d1_q     <= 1'b0;
      dq_d0_q     <= '0;
      dq_d1_q     <= '0;
      dq_oe_q     <= 1'b0;
      rwds_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      ca_q        <= ca_d;
      wdata_q     <= wdata_d;
      rd_hi_q     <= rd_hi_d;
      got_first_q <= got_first_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cs_n_q      <= cs_n_d;
      ck_d0_q     <= ck_d0_d;
      ck_d1_q     <= ck_d1_d;
      dq_d0_q     <= dq_d0_d;
      dq_d1_q     <= dq_d1_d;
      dq_oe_q     <= dq_oe_d;
      rwds_oe_q   <= rwds_oe_d;
    end
  end

  // No byte masking on writes, so RWDS data is always low.
  assign rwds_d0   = 1'b0;
  assign rwds_d1   = 1'b0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign cs_n      = cs_n_q;
  assign ck_d0     = ck_d0_q;
  assign ck_d1     = ck_d1_q;
  assign dq_d0     = dq_d0_q;
  assign dq_d1     = dq_d1_q;
  assign dq_oe     = dq_oe_q;
  assign rwds_oe   = rwds_oe_q;

endmodule

// File: tb/tb_hyperram_ddr_seq.sv
// Directed bench for hyperram_ddr_seq with default parameters; cycle numbers
// count from the handshake edge (cycle 1 follows it).
module tb_hyperram_ddr_seq;

  logic        SCLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [21:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        cs_n;
  logic        ck_d0, ck_d1;
  logic [7:0]  dq_d0, dq_d1;
  logic        dq_oe;
  logic        rwds_d0, rwds_d1, rwds_oe;
  logic [7:0]  dq_q0, dq_q1;
  logic        rwds_q0, rwds_q1;

  int n_chk = 0;
  int n_err = 0;

  // Per-cycle output log of the latest transaction.
  logic       cs_log   [0:79];
  logic       ck0_log  [0:79];
  logic       ck1_log  [0:79];
  logic [7:0] dq0_log  [0:79];
  logic [7:0] dq1_log  [0:79];
  logic       oe_log   [0:79];
  logic       rwoe_log [0:79];
  logic       rwd_log  [0:79];
  int          rsp_cyc, ready_cyc, n_rsp;
  logic [31:0] got_rdata;
  logic        got_err;

  always #5 SCLK = ~SCLK;

  hyperram_ddr_seq dut (
    .SCLK      (SCLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .cs_n      (cs_n),
    .ck_d0     (ck_d0),
    .ck_d1     (ck_d1),
    .dq_d0     (dq_d0),
    .dq_d1     (dq_d1),
    .dq_oe     (dq_oe),
    .rwds_d0   (rwds_d0),
    .rwds_d1   (rwds_d1),
    .rwds_oe   (rwds_oe),
    .dq_q0     (dq_q0),
    .dq_q1     (dq_q1),
    .rwds_q0   (rwds_q0),
    .rwds_q1   (rwds_q1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  // Input DDR stimulus for cycle c. mode 0: silent bus; mode 1: words at
  // 17,18; mode 2: stray toggle at 10, words at 17 and 19 with a gap at 18.
  task automatic drive_rwds(input int mode, input int c);
    rwds_q0 = 1'b0; rwds_q1 = 1'b0; dq_q0 = 8'h00; dq_q1 = 8'h00;
    if (mode == 1 && c == 17) begin rwds_q0 = 1'b1; dq_q0 = 8'hBE; dq_q1 = 8'hEF; end
    if (mode == 1 && c == 18) begin rwds_q1 = 1'b1; dq_q0 = 8'hCA; dq_q1 = 8'hFE; end
    if (mode == 2 && c == 10) begin rwds_q0 = 1'b1; dq_q0 = 8'h11; dq_q1 = 8'h22; end
    if (mode == 2 && c == 17) begin rwds_q0 = 1'b1; dq_q0 = 8'h13; dq_q1 = 8'h57; end
    if (mode == 2 && c == 18) begin rwds_q0 = 1'b1; rwds_q1 = 1'b1; dq_q0 = 8'h99; dq_q1 = 8'h88; end
    if (mode == 2 && c == 19) begin rwds_q1 = 1'b1; dq_q0 = 8'h9B; dq_q1 = 8'hDF; end
  endtask

  task automatic run_txn(input logic we, input logic [21:0] addr, input logic [31:0] wd,
                         input int mode);
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    rsp_cyc = -1; ready_cyc = -1; n_rsp = 0; got_rdata = '0; got_err = 1'b0;
    chk("hs_ready", req_ready, 1'b1);
    tick();
    // Scramble the request inputs: the DUT must have latched them.
    req_valid = 1'b0; req_we = ~we; req_addr = '1; req_wdata = '1;
    for (int c = 1; c <= 70; c++) begin
      cs_log[c] = cs_n; ck0_log[c] = ck_d0; ck1_log[c] = ck_d1;
      dq0_log[c] = dq_d0; dq1_log[c] = dq_d1; oe_log[c] = dq_oe;
      rwoe_log[c] = rwds_oe; rwd_log[c] = rwds_d0 | rwds_d1;
      if (rsp_valid) begin
        n_rsp++; rsp_cyc = c; got_rdata = rsp_rdata; got_err = rsp_err;
      end
      if (req_ready && rsp_cyc >= 0) begin
        ready_cyc = c;
        break;
      end
      drive_rwds(mode, c);
      tick();
    end
    drive_rwds(0, 0);
    $display("txn we=%0d addr=0x%06h rsp_cyc=%0d ready_cyc=%0d rdata=0x%08h err=%0d",
             we, addr, rsp_cyc, ready_cyc, got_rdata, got_err);
  endtask

  initial begin
    RST = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    drive_rwds(0, 0);

    // Reset with a pending request.
    for (int i = 0; i < 3; i++) tick();
    chk("rst_ready", req_ready, 1'b0);
    RST = 1'b0; req_valid = 1'b0;
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_outs", {ck_d0, ck_d1, dq_d0, dq_d1, dq_oe, rwds_d0, rwds_d1, rwds_oe,
                     rsp_valid, rsp_err, rsp_rdata}, '0);
    tick();
    chk("rst_ready_after", req_ready, 1'b1);
    chk("rst_cs_n_after", cs_n, 1'b1);

    // Write 0x12345678 to 0x00000A.
    run_txn(1'b1, 22'h00000A, 32'h12345678, 0);
    chk("wr_setup_cs", {cs_log[1], ck0_log[1], ck1_log[1], oe_log[1]}, 4'b0000);
    chk("wr_ca0", {dq0_log[2], dq1_log[2]}, 16'h2000);
    chk("wr_ca1", {dq0_log[3], dq1_log[3]}, 16'h0001);
    chk("wr_ca2", {dq0_log[4], dq1_log[4]}, 16'h0002);
    chk("wr_ca_ck_oe", {ck0_log[2], ck1_log[2], oe_log[2], oe_log[4], rwoe_log[3]}, 5'b01110);
    chk("wr_lat", {cs_log[5], ck1_log[5], oe_log[5], oe_log[16], rwoe_log[16]}, 5'b01000);
    chk("wr_d0", {dq0_log[17], dq1_log[17]}, 16'h1234);
    chk("wr_d1", {dq0_log[18], dq1_log[18]}, 16'h5678);
    chk("wr_data_ctl", {oe_log[17], rwoe_log[17], oe_log[18], rwoe_log[18], rwd_log[17],
                        ck1_log[18]}, 6'b111101);
    chk("wr_rsp_cyc", rsp_cyc, 19);
    chk("wr_n_rsp", n_rsp, 1);
    chk("wr_hold", {cs_log[19], ck0_log[19], ck1_log[19], oe_log[19], rwoe_log[19]}, 5'b00000);
    chk("wr_recover", {cs_log[20], cs_log[23], ck1_log[20]}, 3'b110);
    chk("wr_ready_cyc", ready_cyc, 24);

    // Read 0x3FFFFF, words 0xBEEF then 0xCAFE.
    run_txn(1'b0, 22'h3FFFFF, 32'h0, 1);
    chk("rd_ca0", {dq0_log[2], dq1_log[2]}, 16'hA007);
    chk("rd_ca1", {dq0_log[3], dq1_log[3]}, 16'hFFFF);
    chk("rd_ca2", {dq0_log[4], dq1_log[4]}, 16'h0007);
    chk("rd_read_ctl", {ck1_log[17], oe_log[17], rwoe_log[17], cs_log[18]}, 4'b1000);
    chk("rd_rsp_cyc", rsp_cyc, 19);
    chk("rd_rdata", got_rdata, 32'hBEEFCAFE);
    chk("rd_err", got_err, 1'b0);
    chk("rd_hold_value", rsp_rdata, 32'hBEEFCAFE);
    chk("rd_ready_cyc", ready_cyc, 24);

    // Read with the bus silent: timeout.
    run_txn(1'b0, 22'h000123, 32'h0, 0);
    chk("to_rsp_cyc", rsp_cyc, 17 + 32);
    chk("to_err", got_err, 1'b1);
    chk("to_rdata", got_rdata, 32'h0);
    chk("to_n_rsp", n_rsp, 1);
    chk("to_ready_cyc", ready_cyc, 54);

    // Read with a stray toggle in LATENCY and a gap between words.
    run_txn(1'b0, 22'h000040, 32'h0, 2);
    chk("gap_rsp_cyc", rsp_cyc, 20);
    chk("gap_rdata", got_rdata, 32'h13579BDF);
    chk("gap_err", got_err, 1'b0);
    chk("gap_hold_cs", cs_log[20], 1'b0);

    // Reset during LATENCY aborts silently.
    req_we = 1'b1; req_addr = 22'h000010; req_wdata = 32'hA5A5A5A5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    chk("ab_in_lat", {cs_n, ck_d1, dq_oe}, 3'b010);
    RST = 1'b1;
    tick();
    chk("ab_rst_pins", {cs_n, ck_d0, ck_d1, dq_oe, rwds_oe, rsp_valid}, 6'b100000);
    RST = 1'b0;
    n_rsp = 0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) n_rsp++;
      tick();
    end
    chk("ab_no_rsp", n_rsp, 0);
    $display("txn aborted write addr=0x000010 rsp_count=%0d", n_rsp);

    run_txn(1'b0, 22'h2AAAA8, 32'h0, 1);
    chk("post_rsp_cyc", rsp_cyc, 19);
    chk("post_rdata", got_rdata, 32'hBEEFCAFE);
    chk("post_ca0", {dq0_log[2], dq1_log[2]}, 16'hA005);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
